avoid_sequencer: RTL and testbench

Drive-direction controller between the direction-request logic (UART command or LFSR pick) and the motor direction decoder.
- Passes the requested direction through to the decoder.
- In RANDOM mode, when the ultrasonic stop flag blocks the requested direction, takes over and runs a timed escape manoeuvre: brake, reverse, turn.
- Counts repeated escapes and latches a fault when the sweeper is trapped.
- Replaces the simple "invert direction while stop is high" behaviour with a sequenced one.

---
 rtl/avoid_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_avoid_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avoid_sequencer.sv
// Drive-direction sequencer: passes requested direction through, and in RANDOM
// mode runs a timed brake/reverse/turn escape when the sonar blocks the request.
module avoid_sequencer #(
    parameter int unsigned TICK_W      = 8,
    parameter int unsigned BRAKE_TICKS = 2,
    parameter int unsigned REV_TICKS   = 8,
    parameter int unsigned TURN_TICKS  = 6,
    parameter int unsigned CLEAR_TICKS = 32,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       enable,
    input  logic       mode,
    input  logic [2:0] cmd_dir,
    input  logic       stop_front,
    input  logic       stop_back,
    input  logic       rand_bit,
    output logic [2:0] dir,
    output logic       busy,
    output logic       fault,
    output logic [2:0] retry
);

    localparam int unsigned DIR_W   = 3;
    localparam int unsigned RETRY_W = 3;

    localparam logic [DIR_W-1:0] DIR_BACK    = 3'b000;
    localparam logic [DIR_W-1:0] DIR_LEFT    = 3'b001;
    localparam logic [DIR_W-1:0] DIR_RIGHT   = 3'b010;
    localparam logic [DIR_W-1:0] DIR_FORWARD = 3'b011;
    localparam logic [DIR_W-1:0] DIR_STOP    = 3'b100;

    localparam logic [TICK_W-1:0]  BRAKE_LAST = TICK_W'(BRAKE_TICKS - 1);
    localparam logic [TICK_W-1:0]  REV_LAST   = TICK_W'(REV_TICKS - 1);
    localparam logic [TICK_W-1:0]  TURN_LAST  = TICK_W'(TURN_TICKS - 1);
    localparam logic [TICK_W-1:0]  CLEAR_LAST = TICK_W'(CLEAR_TICKS - 1);
    localparam logic [TICK_W-1:0]  CLEAR_SAT  = TICK_W'(CLEAR_TICKS);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_PASS,
        ST_BRAKE,
        ST_ESCAPE,
        ST_TURN,
        ST_FAULT
    } state_t;

    state_t             state, state_n;
    logic [TICK_W-1:0]  tick_cnt, tick_cnt_n;
    logic [TICK_W-1:0]  quiet_cnt, quiet_cnt_n;
    logic               blocked_front, blocked_front_n;
    logic               turn_right, turn_right_n;
    logic [DIR_W-1:0]   dir_n;
    logic               busy_n, fault_n;
    logic [RETRY_W-1:0] retry_n;

    logic               obstacle;
    logic               run;
    logic               facing;
    logic [DIR_W-1:0]   pass_dir;
    logic [DIR_W-1:0]   escape_dir;
    logic [DIR_W-1:0]   turn_dir;
    logic [RETRY_W-1:0] retry_inc;

    // Request decoding: what plain pass-through would drive, and the escape targets
    always_comb begin
        obstacle   = ((cmd_dir == DIR_FORWARD) && stop_front) ||
                     ((cmd_dir == DIR_BACK) && stop_back);
        run        = enable && mode;
        if (!enable || obstacle || (cmd_dir > DIR_STOP)) begin
            pass_dir = DIR_STOP;
        end else begin
            pass_dir = cmd_dir;
        end
        escape_dir = blocked_front ? DIR_BACK : DIR_FORWARD;
        facing     = blocked_front ? stop_back : stop_front;
        turn_dir   = turn_right ? DIR_RIGHT : DIR_LEFT;
        retry_inc  = (retry >= RETRY_MAX) ? RETRY_MAX : retry + RETRY_W'(1);
    end

    // Next state and next registered outputs
    always_comb begin
        state_n         = state;
        tick_cnt_n      = tick_cnt;
        quiet_cnt_n     = quiet_cnt;
        blocked_front_n = blocked_front;
        turn_right_n    = turn_right;
        dir_n           = dir;
        busy_n          = busy;
        fault_n         = fault;
        retry_n         = retry;

        case (state)
            ST_PASS: begin
                dir_n   = pass_dir;
                busy_n  = 1'b0;
                fault_n = 1'b0;
                if (run && obstacle) begin
                    blocked_front_n = (cmd_dir == DIR_FORWARD);
                    turn_right_n    = rand_bit;
                    quiet_cnt_n     = '0;
                    retry_n         = retry_inc;
                    dir_n           = DIR_STOP;
                    if (retry_inc == RETRY_MAX) begin
                        state_n = ST_FAULT;
                        fault_n = 1'b1;
                    end else begin
                        state_n = ST_BRAKE;
                        busy_n  = 1'b1;
                    end
                end else if (tick && !obstacle && (quiet_cnt < CLEAR_SAT)) begin
                    quiet_cnt_n = quiet_cnt + TICK_W'(1);
                    if (quiet_cnt == CLEAR_LAST) begin
                        retry_n = '0;
                    end
                end
            end
            ST_BRAKE: begin
                if (!run) begin
                    state_n = ST_PASS;
                    dir_n   = pass_dir;
                    busy_n  = 1'b0;
                end else if (tick) begin
                    if (tick_cnt == BRAKE_LAST) begin
                        state_n = ST_ESCAPE;
                        dir_n   = escape_dir;
                    end else begin
                        tick_cnt_n = tick_cnt + TICK_W'(1);
                    end
                end
            end
            ST_ESCAPE: begin
                if (!run) begin
                    state_n = ST_PASS;
                    dir_n   = pass_dir;
                    busy_n  = 1'b0;
                end else if (facing || (tick && (tick_cnt == REV_LAST))) begin
                    state_n = ST_TURN;
                    dir_n   = turn_dir;
                end else if (tick) begin
                    tick_cnt_n = tick_cnt + TICK_W'(1);
                end
            end
            ST_TURN: begin
                if (!run) begin
                    state_n = ST_PASS;
                    dir_n   = pass_dir;
                    busy_n  = 1'b0;
                end else if (tick) begin
                    if (tick_cnt == TURN_LAST) begin
                        state_n = ST_PASS;
                        dir_n   = pass_dir;
                        busy_n  = 1'b0;
                    end else begin
                        tick_cnt_n = tick_cnt + TICK_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                dir_n  = DIR_STOP;
                busy_n = 1'b0;
                if (!run) begin
                    state_n = ST_PASS;
                    dir_n   = pass_dir;
                    fault_n = 1'b0;
                    retry_n = '0;
                end
            end
            default: begin
                state_n = ST_PASS;
                dir_n   = DIR_STOP;
                busy_n  = 1'b0;
                fault_n = 1'b0;
            end
        endcase

        // Every state starts its tick count from zero
        if (state_n != state) begin
            tick_cnt_n = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_PASS;
            tick_cnt      <= '0;
            quiet_cnt     <= '0;
            blocked_front <= 1'b0;
            turn_right    <= 1'b0;
            dir           <= DIR_STOP;
            busy          <= 1'b0;
            fault         <= 1'b0;
            retry         <= '0;
        end else begin
            state         <= state_n;
            tick_cnt      <= tick_cnt_n;
            quiet_cnt     <= quiet_cnt_n;
            blocked_front <= blocked_front_n;
            turn_right    <= turn_right_n;
            dir           <= dir_n;
            busy          <= busy_n;
            fault         <= fault_n;
            retry         <= retry_n;
        end
    end

endmodule

// File: tb/tb_avoid_sequencer.sv
// Bench for avoid_sequencer: directed scenarios plus randomized traffic, all
// checked against a plan-queue model of the escape behaviour.
module tb_avoid_sequencer;

    localparam logic [2:0] D_BACK  = 3'b000;
    localparam logic [2:0] D_LEFT  = 3'b001;
    localparam logic [2:0] D_RIGHT = 3'b010;
    localparam logic [2:0] D_FWD   = 3'b011;
    localparam logic [2:0] D_STOP  = 3'b100;

    localparam int BRAKE_N = 2;
    localparam int REV_N   = 8;
    localparam int TURN_N  = 6;
    localparam int CLEAR_N = 32;
    localparam int MAX_R   = 3;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       enable;
    logic       mode;
    logic [2:0] cmd_dir;
    logic       stop_front;
    logic       stop_back;
    logic       rand_bit;
    logic [2:0] dir;
    logic       busy;
    logic       fault;
    logic [2:0] retry;

    int n_tests;
    int n_fail;

    avoid_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .enable     (enable),
        .mode       (mode),
        .cmd_dir    (cmd_dir),
        .stop_front (stop_front),
        .stop_back  (stop_back),
        .rand_bit   (rand_bit),
        .dir        (dir),
        .busy       (busy),
        .fault      (fault),
        .retry      (retry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a manoeuvre is a queue of segments (direction, ticks left, sensor that cuts it short)
    typedef struct {
        logic [2:0] d;
        int         left;
        int         watch;   // 0 none, 1 front sensor, 2 rear sensor
    } seg_t;

    seg_t       plan[$];
    logic [2:0] m_dir;
    logic       m_busy;
    logic       m_fault;
    int         m_retry;
    int         m_quiet;

    function automatic bit blocked_now();
        return ((cmd_dir == D_FWD) && stop_front) || ((cmd_dir == D_BACK) && stop_back);
    endfunction

    function automatic logic [2:0] want_dir();
        if (!enable || blocked_now() || (cmd_dir > D_STOP)) return D_STOP;
        return cmd_dir;
    endfunction

    function automatic void model_reset();
        plan.delete();
        m_dir   = D_STOP;
        m_busy  = 1'b0;
        m_fault = 1'b0;
        m_retry = 0;
        m_quiet = 0;
    endfunction

    function automatic void model_step();
        bit go;
        bit done;
        bit front;
        go = enable && mode;
        if (m_fault) begin
            m_dir = D_STOP;
            if (!go) begin
                m_fault = 1'b0;
                m_retry = 0;
                m_dir   = want_dir();
            end
        end else if (plan.size() != 0) begin
            if (!go) begin
                plan.delete();
                m_busy = 1'b0;
                m_dir  = want_dir();
            end else begin
                done = 1'b0;
                if (plan[0].watch == 1 && stop_front) done = 1'b1;
                else if (plan[0].watch == 2 && stop_back) done = 1'b1;
                else if (tick) begin
                    plan[0].left = plan[0].left - 1;
                    done = (plan[0].left == 0);
                end
                if (done) begin
                    void'(plan.pop_front());
                    if (plan.size() != 0) m_dir = plan[0].d;
                    else begin
                        m_busy = 1'b0;
                        m_dir  = want_dir();
                    end
                end
            end
        end else begin
            if (go && blocked_now()) begin
                front   = (cmd_dir == D_FWD);
                m_quiet = 0;
                m_retry = (m_retry + 1 > MAX_R) ? MAX_R : m_retry + 1;
                m_dir   = D_STOP;
                if (m_retry == MAX_R) begin
                    m_fault = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    plan.push_back('{D_STOP, BRAKE_N, 0});
                    plan.push_back('{(front ? D_BACK : D_FWD), REV_N, (front ? 2 : 1)});
                    plan.push_back('{(rand_bit ? D_RIGHT : D_LEFT), TURN_N, 0});
                end
            end else begin
                m_dir = want_dir();
                if (tick && !blocked_now() && m_quiet < CLEAR_N) begin
                    m_quiet = m_quiet + 1;
                    if (m_quiet == CLEAR_N) m_retry = 0;
                end
            end
        end
    endfunction

    // One clock edge: model consumes the same inputs the DUT sampled
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle(input logic [2:0] c);
        tick       = 1'b1;
        enable     = 1'b1;
        mode       = 1'b1;
        cmd_dir    = c;
        stop_front = 1'b0;
        stop_back  = 1'b0;
        rand_bit   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #3;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        set_idle(D_FWD);
        rand_bit   = 1'b1;
        stop_front = 1'b1;
        step();
        stop_front = 1'b0;
        for (int i = 0; i < 11; i++) step();
        n_tests++;
        if (dir !== D_RIGHT || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_turn: dir=%0d busy=%0d, expected dir=%0d busy=1", dir, busy, D_RIGHT);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (dir !== D_STOP || busy !== 1'b0 || fault !== 1'b0 || retry !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_async: dir=%0d busy=%0d fault=%0d retry=%0d, expected 4/0/0/0",
                     dir, busy, fault, retry);
        end
        #2;
        rst = 1'b1;
        step();
        n_tests++;
        if (dir !== D_FWD || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: dir=%0d busy=%0d, expected dir=%0d busy=0", dir, busy, D_FWD);
        end
    endtask

    task automatic test_escape();
        logic [2:0] exp_dir [17];
        for (int i = 0; i < 17; i++) begin
            if (i < 2) exp_dir[i] = D_STOP;
            else if (i < 10) exp_dir[i] = D_BACK;
            else if (i < 16) exp_dir[i] = D_RIGHT;
            else exp_dir[i] = D_FWD;
        end
        do_reset();
        set_idle(D_FWD);
        rand_bit   = 1'b1;
        stop_front = 1'b1;
        step();
        stop_front = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i > 0) step();
            n_tests++;
            if (dir !== exp_dir[i] || busy !== (i < 16) || retry !== 3'd1) begin
                n_fail++;
                $display("FAIL escape_seq[%0d]: dir=%0d busy=%0d retry=%0d, expected dir=%0d busy=%0d retry=1",
                         i, dir, busy, retry, exp_dir[i], (i < 16));
            end
        end
    endtask

    task automatic test_boxed_in();
        do_reset();
        set_idle(D_FWD);
        stop_front = 1'b1;
        stop_back  = 1'b1;
        step();
        step();
        step();
        n_tests++;
        if (dir !== D_BACK || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL boxed_escape: dir=%0d busy=%0d, expected dir=%0d busy=1", dir, busy, D_BACK);
        end
        step();
        stop_front = 1'b0;
        stop_back  = 1'b0;
        for (int i = 0; i < TURN_N; i++) begin
            if (i > 0) step();
            n_tests++;
            if (dir !== D_LEFT || busy !== 1'b1 || dir !== m_dir) begin
                n_fail++;
                $display("FAIL boxed_turn[%0d]: dir=%0d busy=%0d, expected dir=%0d busy=1", i, dir, busy, D_LEFT);
            end
        end
        step();
        n_tests++;
        if (dir !== D_FWD || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL boxed_done: dir=%0d busy=%0d, expected dir=%0d busy=0", dir, busy, D_FWD);
        end
    endtask

    task automatic test_trapped();
        do_reset();
        set_idle(D_FWD);
        for (int k = 0; k < 3; k++) begin
            rand_bit   = 1'($urandom_range(0, 1));
            stop_front = 1'b1;
            step();
            stop_front = 1'b0;
            if (k < 2) begin
                for (int i = 0; i < 16; i++) begin
                    step();
                    n_tests++;
                    if (dir !== m_dir || busy !== m_busy || retry !== 3'(m_retry)) begin
                        n_fail++;
                        $display("FAIL trapped_run[%0d.%0d]: dir=%0d busy=%0d retry=%0d, expected %0d/%0d/%0d",
                                 k, i, dir, busy, retry, m_dir, m_busy, m_retry);
                    end
                end
            end
        end
        step();
        n_tests++;
        if (dir !== D_STOP || fault !== 1'b1 || retry !== 3'd3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL trapped_fault: dir=%0d fault=%0d retry=%0d busy=%0d, expected 4/1/3/0",
                     dir, fault, retry, busy);
        end
        enable = 1'b0;
        step();
        n_tests++;
        if (fault !== 1'b0 || retry !== 3'd0 || dir !== D_STOP) begin
            n_fail++;
            $display("FAIL trapped_clear: fault=%0d retry=%0d dir=%0d, expected 0/0/4", fault, retry, dir);
        end
    endtask

    task automatic test_quiet_reset();
        do_reset();
        set_idle(D_FWD);
        stop_front = 1'b1;
        step();
        stop_front = 1'b0;
        for (int i = 0; i < 16; i++) step();
        for (int i = 0; i < CLEAR_N - 1; i++) step();
        n_tests++;
        if (retry !== 3'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL quiet_hold: retry=%0d busy=%0d, expected retry=1 busy=0", retry, busy);
        end
        step();
        n_tests++;
        if (retry !== 3'd0) begin
            n_fail++;
            $display("FAIL quiet_clear: retry=%0d, expected 0", retry);
        end
        stop_front = 1'b1;
        step();
        stop_front = 1'b0;
        n_tests++;
        if (retry !== 3'd1 || fault !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL quiet_retrigger: retry=%0d fault=%0d busy=%0d, expected 1/0/1", retry, fault, busy);
        end
    endtask

    task automatic test_control_abort();
        do_reset();
        set_idle(D_BACK);
        mode      = 1'b0;
        stop_back = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (dir !== D_STOP || busy !== 1'b0 || retry !== 3'd0) begin
                n_fail++;
                $display("FAIL control_block[%0d]: dir=%0d busy=%0d retry=%0d, expected 4/0/0", i, dir, busy, retry);
            end
        end
        mode       = 1'b1;
        cmd_dir    = D_FWD;
        stop_back  = 1'b0;
        stop_front = 1'b1;
        step();
        stop_front = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_tests++;
        if (dir !== D_BACK || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reversing: dir=%0d busy=%0d, expected dir=%0d busy=1", dir, busy, D_BACK);
        end
        mode    = 1'b0;
        cmd_dir = D_LEFT;
        step();
        n_tests++;
        if (dir !== D_LEFT || busy !== 1'b0 || retry !== 3'd1) begin
            n_fail++;
            $display("FAIL abort_exit: dir=%0d busy=%0d retry=%0d, expected dir=%0d busy=0 retry=1",
                     dir, busy, retry, D_LEFT);
        end
    endtask

    task automatic test_random();
        do_reset();
        set_idle(D_STOP);
        for (int i = 0; i < 4000; i++) begin
            tick       = 1'($urandom_range(0, 1));
            enable     = ($urandom_range(0, 99) < 97);
            mode       = ($urandom_range(0, 99) < 92);
            cmd_dir    = 3'($urandom_range(0, 7));
            stop_front = ($urandom_range(0, 99) < 25);
            stop_back  = ($urandom_range(0, 99) < 25);
            rand_bit   = 1'($urandom_range(0, 1));
            step();
            n_tests++;
            if (dir !== m_dir || busy !== m_busy || fault !== m_fault || retry !== 3'(m_retry)) begin
                n_fail++;
                $display("FAIL random[%0d]: dir=%0d busy=%0d fault=%0d retry=%0d, expected %0d/%0d/%0d/%0d",
                         i, dir, busy, fault, retry, m_dir, m_busy, m_fault, m_retry);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        set_idle(D_STOP);
        model_reset();
        #7;
        test_reset();
        test_escape();
        test_boxed_in();
        test_trapped();
        test_quiet_reset();
        test_control_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
